// File: rtl/fp_pair_sweeper_pkg.sv
// rtl/fp_pair_sweeper_pkg.sv - shared defaults and sweep FSM state encodings
package fp_pair_sweeper_pkg;

  localparam int SW_NEXP = 5;
  localparam int SW_NSIG = 10;

  typedef enum logic [1:0] {
    SW_IDLE = 2'd0,
    SW_RUN  = 2'd1,
    SW_ERR  = 2'd2,
    SW_DONE = 2'd3
  } sw_state_e;

endpackage

// File: rtl/fp_finite_next.sv
// rtl/fp_finite_next.sv - successor of a finite binary16-style encoding in sweep order
module fp_finite_next #(
  parameter int NEXP = 5,
  parameter int NSIG = 10,
  parameter int W    = NEXP + NSIG + 1
) (
  input  logic [W-1:0] i_x,
  input  logic         i_pos_only,
  output logic [W-1:0] o_next,
  output logic         o_is_last
);

  // Largest finite positive: exponent all ones except LSB, significand all ones.
  localparam logic [W-1:0] MAXP = {1'b0, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
  localparam logic [W-1:0] NEGZ = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXN = {1'b1, MAXP[W-2:0]};

  logic [W-1:0] w_last;

  assign w_last    = i_pos_only ? MAXP : MAXN;
  assign o_next    = (i_x == MAXP) ? NEGZ : i_x + {{(W-1){1'b0}}, 1'b1};
  assign o_is_last = (i_x == w_last);

endmodule

// File: rtl/fp_pair_sweeper.sv
// rtl/fp_pair_sweeper.sv - walks all ordered pairs of finite operands, stops on mismatch or end
module fp_pair_sweeper
  import fp_pair_sweeper_pkg::*;
#(
  parameter int NEXP = SW_NEXP,
  parameter int NSIG = SW_NSIG,
  parameter int W    = NEXP + NSIG + 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         step,
  input  logic         start,
  input  logic         hold,
  input  logic         pos_only,
  input  logic         mismatch,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         running,
  output logic         done,
  output logic         error,
  output logic [31:0]  pair_count
);

  sw_state_e   r_state, w_state_nx;
  logic [W-1:0] r_a, r_b, w_a_nx, w_b_nx;
  logic [31:0]  r_cnt, w_cnt_nx;
  logic         r_pos, w_pos_nx;

  logic [W-1:0] w_a_next, w_b_next;
  logic         w_a_last, w_b_last;

  fp_finite_next #(.NEXP(NEXP), .NSIG(NSIG), .W(W)) u_next_a (
    .i_x        (r_a),
    .i_pos_only (r_pos),
    .o_next     (w_a_next),
    .o_is_last  (w_a_last)
  );

  fp_finite_next #(.NEXP(NEXP), .NSIG(NSIG), .W(W)) u_next_b (
    .i_x        (r_b),
    .i_pos_only (r_pos),
    .o_next     (w_b_next),
    .o_is_last  (w_b_last)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= SW_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_pos   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_cnt   <= w_cnt_nx;
      r_pos   <= w_pos_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_cnt_nx   = r_cnt;
    w_pos_nx   = r_pos;
    if (step) begin
      case (r_state)
        SW_IDLE: begin
          if (start) begin
            w_pos_nx   = pos_only;
            w_a_nx     = '0;
            w_b_nx     = '0;
            w_cnt_nx   = '0;
            w_state_nx = SW_RUN;
          end
        end
        SW_RUN: begin
          // A mismatch freezes the failing pair, even on the final pair.
          if (!hold) begin
            if (mismatch) begin
              w_state_nx = SW_ERR;
            end else begin
              w_cnt_nx = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
              if (!w_b_last) begin
                w_b_nx = w_b_next;
              end else if (!w_a_last) begin
                w_b_nx = '0;
                w_a_nx = w_a_next;
              end else begin
                w_state_nx = SW_DONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign a          = r_a;
  assign b          = r_b;
  assign pair_count = r_cnt;
  assign running    = (r_state == SW_RUN);
  assign done       = (r_state == SW_DONE);
  assign error      = (r_state == SW_ERR);

endmodule

// File: tb/tb_fp_pair_sweeper.sv
// tb/tb_fp_pair_sweeper.sv - directed bench for fp_pair_sweeper
module tb_fp_pair_sweeper;

  logic        clk, clr_n, step, start, hold, pos_only, mismatch;
  logic [15:0] a, b;
  logic        running, done, error;
  logic [31:0] pair_count;

  int checks   = 0;
  int failures = 0;
  int infnan   = 0;

  fp_pair_sweeper dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .step       (step),
    .start      (start),
    .hold       (hold),
    .pos_only   (pos_only),
    .mismatch   (mismatch),
    .a          (a),
    .b          (b),
    .running    (running),
    .done       (done),
    .error      (error),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) infnan++;
  end

  typedef struct {
    logic        s, st, h, m;
    logic [15:0] ea, eb;
    logic [31:0] ec;
    logic [2:0]  ef;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [31:0] ec, input logic [2:0] ef);
    chk({nm, ".a"}, {16'h0, a}, {16'h0, ea});
    chk({nm, ".b"}, {16'h0, b}, {16'h0, eb});
    chk({nm, ".cnt"}, pair_count, ec);
    chk({nm, ".flags"}, {29'h0, running, done, error}, {29'h0, ef});
  endtask

  task automatic tick(input logic s, input logic st, input logic h, input logic m);
    step = s; start = st; hold = h; mismatch = m;
    @(posedge clk); #1;
    step = 0; start = 0; hold = 0; mismatch = 0;
  endtask

  task automatic do_reset();
    #2 clr_n = 0;
    @(posedge clk); #1;
    clr_n = 1;
  endtask

  task automatic set_ab(input logic [15:0] fa, input logic [15:0] fb);
    force dut.r_a = fa;
    force dut.r_b = fb;
    #1;
    release dut.r_a;
    release dut.r_b;
  endtask

  vec_t vt[8];

  initial begin
    clr_n = 0; step = 0; start = 0; hold = 0; pos_only = 0; mismatch = 0;
    // {step,start,hold,mismatch} -> {a,b,count,{running,done,error}}
    vt[0] = '{1, 1, 0, 1, 16'h0000, 16'h0000, 32'd0, 3'b100};
    vt[1] = '{1, 0, 0, 0, 16'h0000, 16'h0001, 32'd1, 3'b100};
    vt[2] = '{0, 0, 0, 1, 16'h0000, 16'h0001, 32'd1, 3'b100};
    vt[3] = '{1, 0, 1, 1, 16'h0000, 16'h0001, 32'd1, 3'b100};
    vt[4] = '{1, 1, 0, 0, 16'h0000, 16'h0002, 32'd2, 3'b100};
    vt[5] = '{1, 0, 0, 0, 16'h0000, 16'h0003, 32'd3, 3'b100};
    vt[6] = '{1, 0, 0, 1, 16'h0000, 16'h0003, 32'd3, 3'b001};
    vt[7] = '{1, 1, 0, 0, 16'h0000, 16'h0003, 32'd3, 3'b001};

    #12;
    chk_all("reset", 16'h0, 16'h0, 32'd0, 3'b000);
    @(posedge clk); #1;
    clr_n = 1;
    tick(1, 0, 0, 0);
    chk_all("idle_no_start", 16'h0, 16'h0, 32'd0, 3'b000);

    for (int i = 0; i < 8; i++) begin
      tick(vt[i].s, vt[i].st, vt[i].h, vt[i].m);
      chk_all($sformatf("vec%0d", i), vt[i].ea, vt[i].eb, vt[i].ec, vt[i].ef);
    end

    // Positive-only sweep: b wraps after 31744 values
    do_reset();
    pos_only = 1;
    tick(1, 1, 0, 0);
    pos_only = 0;
    tick(1, 0, 0, 0);
    chk_all("pos_first", 16'h0, 16'h1, 32'd1, 3'b100);
    for (int i = 1; i < 31744; i++) tick(1, 0, 0, 0);
    chk_all("pos_wrap", 16'h1, 16'h0, 32'd31744, 3'b100);

    for (int i = 0; i < 10; i++) tick(1, 0, 1, 1);
    chk_all("hold", 16'h1, 16'h0, 32'd31744, 3'b100);
    tick(1, 0, 0, 0);
    chk_all("hold_release", 16'h1, 16'h1, 32'd31745, 3'b100);

    // Asynchronous reset between edges
    #2 clr_n = 0;
    #1;
    chk_all("async_reset", 16'h0, 16'h0, 32'd0, 3'b000);
    @(posedge clk); #1;
    clr_n = 1;
    tick(1, 1, 0, 0);
    chk_all("restart", 16'h0, 16'h0, 32'd0, 3'b100);

    // Full ordering: MAXP -> NEGZ, MAXN wraps b and advances a
    set_ab(16'h0000, 16'h7BFF);
    tick(1, 0, 0, 0);
    chk_all("maxp_to_negz", 16'h0000, 16'h8000, 32'd1, 3'b100);
    set_ab(16'h0005, 16'hFBFF);
    tick(1, 0, 0, 0);
    chk_all("b_wrap_full", 16'h0006, 16'h0000, 32'd2, 3'b100);
    set_ab(16'h7BFF, 16'hFBFF);
    tick(1, 0, 0, 0);
    chk_all("a_maxp_to_negz", 16'h8000, 16'h0000, 32'd3, 3'b100);

    set_ab(16'hFBFF, 16'hFBFF);
    tick(1, 0, 0, 0);
    chk_all("done", 16'hFBFF, 16'hFBFF, 32'd4, 3'b010);
    tick(1, 1, 0, 1);
    tick(1, 0, 0, 0);
    chk_all("done_sticky", 16'hFBFF, 16'hFBFF, 32'd4, 3'b010);

    // Failing pair is frozen
    do_reset();
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    set_ab(16'h0003, 16'h8010);
    tick(1, 0, 0, 1);
    chk_all("err", 16'h0003, 16'h8010, 32'd1, 3'b001);
    tick(1, 1, 0, 0);
    chk_all("err_start_ignored", 16'h0003, 16'h8010, 32'd1, 3'b001);

    // Mismatch on the final pair wins over completion
    do_reset();
    tick(1, 1, 0, 0);
    set_ab(16'hFBFF, 16'hFBFF);
    tick(1, 0, 0, 1);
    chk_all("last_mismatch", 16'hFBFF, 16'hFBFF, 32'd0, 3'b001);

    // Counter saturates
    do_reset();
    tick(1, 1, 0, 0);
    force dut.r_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_cnt;
    tick(1, 0, 0, 0);
    chk_all("cnt_sat", 16'h0, 16'h1, 32'hFFFF_FFFF, 3'b100);

    // Positive-only end of sweep stops at MAXP/MAXP
    do_reset();
    pos_only = 1;
    tick(1, 1, 0, 0);
    pos_only = 0;
    set_ab(16'h7BFF, 16'h7BFF);
    tick(1, 0, 0, 0);
    chk_all("pos_done", 16'h7BFF, 16'h7BFF, 32'd1, 3'b010);

    chk("no_infnan", infnan, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
